// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core
//   Multi-cycle RISC-V integer core. Each instruction goes FETCH -> EXEC,
//   plus MEM for loads/stores. Supports ADDI, ADD, SUB, LUI, AUIPC, JAL,
//   JALR, BEQ, BNE and XLEN-wide load/store (LD/SD at 64, LW/SW at 32).
//   ir == 0 or EBREAK retires and halts; any other encoding, a misaligned
//   data address or a jump/branch target with bit 1 set halts with err.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   imem_*                instruction fetch handshake (valid/ready, rdata same cycle)
//   dmem_*                data access handshake (valid/ready, rdata same cycle)
//   pc_o                  current PC
//   commit_valid_o/pc_o   one-cycle pulse + PC per retired instruction
//   halt_o, err_o         sticky stop flags
module rv_multicycle_core #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_valid_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            dmem_valid_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ready_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic            commit_valid_o,
    output logic [XLEN-1:0] commit_pc_o,
    output logic            halt_o,
    output logic            err_o
);

    localparam int unsigned NREGS = 32;
    // Data address LSBs that must be zero for an XLEN-wide access
    localparam int unsigned AW    = (XLEN == 64) ? 3 : 2;
    localparam logic [2:0]  LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;
    typedef enum logic [1:0] {EX_WB, EX_MEM, EX_HALT, EX_ERR} exec_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     ir_q;
    logic [XLEN-1:0] regs_q [NREGS];
    logic            commit_valid_q;
    logic [XLEN-1:0] commit_pc_q;
    logic            halt_q;
    logic            err_q;
    logic            dmem_we_q;
    logic [XLEN-1:0] dmem_addr_q;
    logic [XLEN-1:0] dmem_wdata_q;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd_idx, rs1_idx, rs2_idx;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode  = ir_q[6:0];
    assign rd_idx  = ir_q[11:7];
    assign funct3  = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign funct7  = ir_q[31:25];

    // Sign-extended immediates
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign imm_i = XLEN'($signed(ir_q[31:20]));
    assign imm_s = XLEN'($signed({ir_q[31:25], ir_q[11:7]}));
    assign imm_b = XLEN'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({ir_q[31:12], 12'h000}));

    // Operands; x0 is never written, so regs_q[0] always reads zero
    logic [XLEN-1:0] rs1_v, rs2_v;
    logic [XLEN-1:0] pc_plus4, jalr_tgt;

    assign rs1_v    = regs_q[rs1_idx];
    assign rs2_v    = regs_q[rs2_idx];
    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_tgt = (rs1_v + imm_i) & ~XLEN'(1);

    // EXEC decode: outcome, writeback, next PC and data request
    exec_e           exec_kind;
    logic            wb_en;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] mem_addr_d;
    logic            mem_we_d;

    always_comb begin
        exec_kind  = EX_ERR;
        wb_en      = 1'b0;
        wb_data    = '0;
        pc_d       = pc_plus4;
        mem_addr_d = rs1_v + imm_i;
        mem_we_d   = 1'b0;

        case (opcode)
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    exec_kind = EX_WB;
                    wb_en     = 1'b1;
                    wb_data   = rs1_v + imm_i;
                end
            end
            OP_REG: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    exec_kind = EX_WB;
                    wb_en     = 1'b1;
                    wb_data   = rs1_v + rs2_v;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    exec_kind = EX_WB;
                    wb_en     = 1'b1;
                    wb_data   = rs1_v - rs2_v;
                end
            end
            OP_LUI: begin
                exec_kind = EX_WB;
                wb_en     = 1'b1;
                wb_data   = imm_u;
            end
            OP_AUIPC: begin
                exec_kind = EX_WB;
                wb_en     = 1'b1;
                wb_data   = pc_q + imm_u;
            end
            OP_JAL: begin
                exec_kind = EX_WB;
                wb_en     = 1'b1;
                wb_data   = pc_plus4;
                pc_d      = pc_q + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    exec_kind = EX_WB;
                    wb_en     = 1'b1;
                    wb_data   = pc_plus4;
                    pc_d      = jalr_tgt;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    exec_kind = EX_WB;
                    if (rs1_v == rs2_v) pc_d = pc_q + imm_b;
                end else if (funct3 == 3'b001) begin
                    exec_kind = EX_WB;
                    if (rs1_v != rs2_v) pc_d = pc_q + imm_b;
                end
            end
            OP_LOAD: begin
                if (funct3 == LS_F3) exec_kind = EX_MEM;
            end
            OP_STORE: begin
                if (funct3 == LS_F3) begin
                    exec_kind  = EX_MEM;
                    mem_addr_d = rs1_v + imm_s;
                    mem_we_d   = 1'b1;
                end
            end
            default: begin
                if (ir_q == 32'h0 || ir_q == EBREAK) exec_kind = EX_HALT;
            end
        endcase

        // pc+4 is always aligned, so bit 1 can only come from a jump/taken branch
        if (exec_kind == EX_WB && pc_d[1]) exec_kind = EX_ERR;
        if (exec_kind == EX_MEM && (|mem_addr_d[AW-1:0])) exec_kind = EX_ERR;
    end

    // Core FSM, register file and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            ir_q           <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            halt_q         <= 1'b0;
            err_q          <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wdata_q   <= '0;
        end else begin
            commit_valid_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem_ready_i) begin
                        ir_q    <= imem_rdata_i;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (exec_kind)
                        EX_WB: begin
                            if (wb_en && rd_idx != 5'd0) regs_q[rd_idx] <= wb_data;
                            pc_q           <= pc_d;
                            commit_valid_q <= 1'b1;
                            commit_pc_q    <= pc_q;
                            state_q        <= S_FETCH;
                        end
                        EX_MEM: begin
                            dmem_we_q    <= mem_we_d;
                            dmem_addr_q  <= mem_addr_d;
                            dmem_wdata_q <= rs2_v;
                            state_q      <= S_MEM;
                        end
                        EX_HALT: begin
                            commit_valid_q <= 1'b1;
                            commit_pc_q    <= pc_q;
                            halt_q         <= 1'b1;
                            state_q        <= S_HALT;
                        end
                        EX_ERR: begin
                            halt_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_HALT;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready_i) begin
                        if (!dmem_we_q && rd_idx != 5'd0) regs_q[rd_idx] <= dmem_rdata_i;
                        pc_q           <= pc_plus4;
                        commit_valid_q <= 1'b1;
                        commit_pc_q    <= pc_q;
                        state_q        <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    // Request strobes follow the state directly and drop the moment reset asserts
    assign imem_valid_o   = (state_q == S_FETCH) && !rst_i;
    assign dmem_valid_o   = (state_q == S_MEM) && !rst_i;
    assign imem_addr_o    = pc_q;
    assign dmem_we_o      = dmem_we_q;
    assign dmem_addr_o    = dmem_addr_q;
    assign dmem_wdata_o   = dmem_wdata_q;
    assign pc_o           = pc_q;
    assign commit_valid_o = commit_valid_q;
    assign commit_pc_o    = commit_pc_q;
    assign halt_o         = halt_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb_rv_multicycle_core
//   Directed and random programs for rv_multicycle_core (XLEN=64), checked
//   cycle by cycle against an instruction-level model of the ISA subset.
module tb_rv_multicycle_core;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] RPC  = 64'h8000_0000;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    localparam int PH_FETCH = 0, PH_EXEC = 1, PH_MEM = 2, PH_HALT = 3;
    localparam int K_WB = 0, K_MEM = 1, K_HALT = 2, K_ERR = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_valid, imem_ready;
    logic [63:0]     imem_addr;
    logic [31:0]     imem_rdata;
    logic            dmem_valid, dmem_we, dmem_ready;
    logic [63:0]     dmem_addr, dmem_wdata, dmem_rdata;
    logic [63:0]     pc, commit_pc;
    logic            commit_valid, halt, err;

    rv_multicycle_core #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_valid_o(imem_valid), .imem_addr_o(imem_addr),
        .imem_ready_i(imem_ready), .imem_rdata_i(imem_rdata),
        .dmem_valid_o(dmem_valid), .dmem_we_o(dmem_we),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_ready_i(dmem_ready), .dmem_rdata_i(dmem_rdata),
        .pc_o(pc), .commit_valid_o(commit_valid), .commit_pc_o(commit_pc),
        .halt_o(halt), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Environment: program image from RPC, data memory aliased on addr[8:3]
    logic [31:0] prog [256];
    logic [63:0] mem  [64];

    // Model state
    logic [63:0] m_x [32];
    logic [63:0] m_pc, m_next;
    int          m_kind;
    logic [63:0] e_addr, e_wdata;
    logic        e_we;
    int          e_rd;

    // Handshake pacing: 0 always ready, 1 random, 2 fixed delay (data only)
    int imode, dmode, dly;
    int ph;
    bit exp_commit, exp_halt, exp_err;
    logic [63:0] exp_cpc;
    logic [63:0] cq_pc [$];
    int          cq_t  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fetch(input logic [63:0] a);
        if (a >= RPC && a < RPC + 64'd1024) return prog[8'((a - RPC) >> 2)];
        return 32'h0;
    endfunction

    // Instruction encoders
    function automatic logic [31:0] e_i(input logic [6:0] op, input int rd, input logic [2:0] f3,
                                        input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] e_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] e_s(input int rs1, input int rs2, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] e_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] e_j(input int rd, input int imm);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] e_u(input logic [6:0] op, input int rd, input int imm20);
        return {20'(imm20), 5'(rd), op};
    endfunction

    // One instruction at ISA level: classify, set next PC / request, write rd
    task automatic m_exec(input logic [31:0] in);
        logic [63:0] a, b, ii, is, ib, ij, iu, nxt, val;
        logic        wr;
        int          rd;
        a   = m_x[in[19:15]];
        b   = m_x[in[24:20]];
        rd  = int'(in[11:7]);
        ii  = {{52{in[31]}}, in[31:20]};
        is  = {{52{in[31]}}, in[31:25], in[11:7]};
        ib  = {{51{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
        ij  = {{43{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
        iu  = {{32{in[31]}}, in[31:12], 12'h000};
        nxt = m_pc + 64'd4;
        wr  = 1'b0;
        val = '0;
        m_kind = K_ERR;
        casez (in)
            32'b?????????????????000?????0010011: begin m_kind = K_WB; wr = 1; val = a + ii; end
            32'b0000000??????????000?????0110011: begin m_kind = K_WB; wr = 1; val = a + b; end
            32'b0100000??????????000?????0110011: begin m_kind = K_WB; wr = 1; val = a - b; end
            32'b?????????????????????????0110111: begin m_kind = K_WB; wr = 1; val = iu; end
            32'b?????????????????????????0010111: begin m_kind = K_WB; wr = 1; val = m_pc + iu; end
            32'b?????????????????????????1101111: begin
                m_kind = K_WB; wr = 1; val = m_pc + 64'd4; nxt = m_pc + ij;
            end
            32'b?????????????????000?????1100111: begin
                m_kind = K_WB; wr = 1; val = m_pc + 64'd4; nxt = (a + ii) & ~64'd1;
            end
            32'b?????????????????000?????1100011: begin m_kind = K_WB; if (a == b) nxt = m_pc + ib; end
            32'b?????????????????001?????1100011: begin m_kind = K_WB; if (a != b) nxt = m_pc + ib; end
            32'b?????????????????011?????0000011: begin
                m_kind = K_MEM; e_addr = a + ii; e_we = 1'b0; e_rd = rd;
            end
            32'b?????????????????011?????0100011: begin
                m_kind = K_MEM; e_addr = a + is; e_we = 1'b1; e_wdata = b; e_rd = 0;
            end
            32'h0000_0000, EBRK: m_kind = K_HALT;
            default: m_kind = K_ERR;
        endcase
        if (m_kind == K_MEM && e_addr[2:0] != 3'b000) m_kind = K_ERR;
        if (m_kind == K_WB && nxt[1]) m_kind = K_ERR;
        if (m_kind == K_WB) begin
            if (wr && rd != 0) m_x[rd] = val;
            m_next = nxt;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk("rst_imem_valid", 64'(imem_valid), 0);
        chk("rst_dmem_valid", 64'(dmem_valid), 0);
        @(negedge clk);
        chk("rst_pc", pc, RPC);
        chk("rst_commit", 64'(commit_valid), 0);
        chk("rst_halt", 64'(halt), 0);
        chk("rst_err", 64'(err), 0);
        rst = 1'b0;
        m_pc = RPC;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    endtask

    // Compare process: per-cycle expectations until halted (3 cycles) or abort
    task automatic run_prog(input int budget, input int abort_w);
        int cyc, wcnt, hcnt;
        bit done, rdy;
        logic [31:0] cur_ir;
        cyc = 0; wcnt = 0; hcnt = 0; done = 0; cur_ir = '0;
        ph = PH_FETCH; exp_commit = 0; exp_halt = 0; exp_err = 0;
        cq_pc.delete(); cq_t.delete();
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            chk("commit_valid", 64'(commit_valid), 64'(exp_commit));
            if (exp_commit) begin
                chk("commit_pc", commit_pc, exp_cpc);
                cq_pc.push_back(exp_cpc);
                cq_t.push_back(cyc);
            end
            exp_commit = 0;
            case (ph)
                PH_FETCH: begin
                    chk("imem_valid", 64'(imem_valid), 1);
                    chk("imem_addr", imem_addr, m_pc);
                    chk("pc", pc, m_pc);
                    chk("dmem_valid", 64'(dmem_valid), 0);
                    chk("halt", 64'(halt), 0);
                    chk("err", 64'(err), 0);
                    rdy = (imode == 0) || ($urandom_range(0, 2) == 0);
                    imem_ready = rdy;
                    imem_rdata = fetch(imem_addr);
                    if (rdy) begin
                        cur_ir = fetch(m_pc);
                        ph = PH_EXEC;
                    end
                end
                PH_EXEC: begin
                    chk("exec_imem_valid", 64'(imem_valid), 0);
                    chk("exec_dmem_valid", 64'(dmem_valid), 0);
                    chk("exec_pc", pc, m_pc);
                    chk("exec_halt", 64'(halt), 0);
                    m_exec(cur_ir);
                    wcnt = 0;
                    case (m_kind)
                        K_WB:   begin exp_commit = 1; exp_cpc = m_pc; m_pc = m_next; ph = PH_FETCH; end
                        K_MEM:  ph = PH_MEM;
                        K_HALT: begin exp_commit = 1; exp_cpc = m_pc; exp_halt = 1; exp_err = 0; ph = PH_HALT; end
                        default: begin exp_halt = 1; exp_err = 1; ph = PH_HALT; end
                    endcase
                end
                PH_MEM: begin
                    chk("dmem_valid", 64'(dmem_valid), 1);
                    chk("dmem_we", 64'(dmem_we), 64'(e_we));
                    chk("dmem_addr", dmem_addr, e_addr);
                    if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
                    chk("mem_imem_valid", 64'(imem_valid), 0);
                    chk("mem_halt", 64'(halt), 0);
                    if (abort_w >= 0 && wcnt == abort_w) begin
                        done = 1;
                    end else begin
                        rdy = (dmode == 0) || (dmode == 1 && $urandom_range(0, 2) == 0) ||
                              (dmode == 2 && wcnt >= dly);
                        dmem_ready = rdy;
                        dmem_rdata = mem[e_addr[8:3]];
                        if (rdy) begin
                            if (e_we) mem[e_addr[8:3]] = e_wdata;
                            else if (e_rd != 0) m_x[e_rd] = mem[e_addr[8:3]];
                            exp_commit = 1; exp_cpc = m_pc; m_pc = m_pc + 64'd4; ph = PH_FETCH;
                        end else begin
                            wcnt++;
                        end
                    end
                end
                default: begin
                    chk("halt", 64'(halt), 64'(exp_halt));
                    chk("err", 64'(err), 64'(exp_err));
                    chk("halt_imem_valid", 64'(imem_valid), 0);
                    chk("halt_dmem_valid", 64'(dmem_valid), 0);
                    chk("halt_pc", pc, m_pc);
                    hcnt++;
                    if (hcnt >= 3) done = 1;
                end
            endcase
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: no halt after %0d cycles, phase %0d", budget, ph);
        end
    endtask

    function automatic logic [31:0] rand_instr(input int pos, input int n);
        int k, sel, off;
        sel = $urandom_range(0, 15);
        k   = $urandom_range(1, 4);
        off = ($urandom_range(0, 7) == 0) ? 4 * k + 2 : 4 * k;
        case (sel)
            0, 1, 2: return e_i(7'b0010011, $urandom_range(0, 7), 3'b000, $urandom_range(0, 7),
                                $urandom_range(0, 4095));
            3:  return e_r(7'b0000000, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            4:  return e_r(7'b0100000, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            5:  return e_u(7'b0110111, $urandom_range(0, 7), $urandom);
            6:  return e_u(7'b0010111, $urandom_range(0, 7), $urandom);
            7, 8: return e_s(0, $urandom_range(0, 7), 8 * $urandom_range(0, 31));
            9, 10: return e_i(7'b0000011, $urandom_range(0, 7), 3'b011, 0, 8 * $urandom_range(0, 31));
            11: return e_b(3'b000, $urandom_range(0, 3), $urandom_range(0, 3), off);
            12: return e_b(3'b001, $urandom_range(0, 3), $urandom_range(0, 3), off);
            13: return e_j($urandom_range(0, 7), off);
            14: return e_i(7'b0000011, $urandom_range(1, 7), 3'b011, 0, 8 * $urandom_range(0, 31) + 4);
            default: begin
                if (pos > n - 3 && $urandom_range(0, 1) == 0) return $urandom;
                return e_i(7'b0010011, $urandom_range(0, 7), 3'b000, $urandom_range(0, 7), 1);
            end
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        imem_ready = 1'b0; imem_rdata = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        imode = 0; dmode = 0; dly = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        clear_prog();

        // ALU sequence, zero-wait
        prog[0] = e_i(7'b0010011, 1, 3'b000, 0, 5);
        prog[1] = e_r(7'b0000000, 2, 1, 1);
        prog[2] = e_r(7'b0100000, 3, 2, 1);
        prog[3] = e_s(0, 2, 0);
        prog[4] = e_s(0, 3, 8);
        prog[5] = EBRK;
        do_reset();
        run_prog(200, -1);
        chk("alu_x2", m_x[2], 64'd10);
        chk("alu_x3", m_x[3], 64'd5);
        chk("alu_mem0", mem[0], 64'd10);
        chk("alu_mem1", mem[1], 64'd5);
        chk("alu_ncommit", 64'(cq_pc.size()), 6);
        if (cq_pc.size() >= 3) begin
            chk("alu_cpc0", cq_pc[0], 64'h8000_0000);
            chk("alu_cpc1", cq_pc[1], 64'h8000_0004);
            chk("alu_cpc2", cq_pc[2], 64'h8000_0008);
            chk("alu_lat1", 64'(cq_t[1] - cq_t[0]), 2);
            chk("alu_lat2", 64'(cq_t[2] - cq_t[1]), 2);
        end

        // LUI / AUIPC
        clear_prog();
        for (int i = 0; i < 3; i++) prog[i] = e_i(7'b0010011, 0, 3'b000, 0, 0);
        prog[3] = e_u(7'b0110111, 5, 32'h80000);
        prog[4] = e_u(7'b0010111, 6, 1);
        prog[5] = e_s(0, 5, 0);
        prog[6] = e_s(0, 6, 8);
        prog[7] = EBRK;
        do_reset();
        run_prog(200, -1);
        chk("lui_x5", mem[0], 64'hFFFF_FFFF_8000_0000);
        chk("auipc_x6", mem[1], 64'h0000_0000_8000_1010);

        // JAL / JALR / branches
        clear_prog();
        prog[0] = e_j(1, 8);
        prog[1] = e_j(0, 8);
        prog[2] = e_i(7'b1100111, 0, 3'b000, 1, 0);
        prog[3] = e_b(3'b001, 0, 0, 8);
        prog[4] = e_s(0, 1, 0);
        prog[5] = e_b(3'b000, 0, 0, 8);
        prog[6] = EBRK;
        prog[7] = e_b(3'b000, 0, 0, -4);
        do_reset();
        run_prog(200, -1);
        chk("jal_x1", mem[0], 64'h8000_0004);
        chk("jmp_ncommit", 64'(cq_pc.size()), 8);
        if (cq_pc.size() == 8) begin
            chk("jmp_pc1", cq_pc[1], 64'h8000_0008);
            chk("jmp_pc2", cq_pc[2], 64'h8000_0004);
            chk("jmp_pc4", cq_pc[4], 64'h8000_0010);
            chk("jmp_pc6", cq_pc[6], 64'h8000_001C);
            chk("jmp_pc7", cq_pc[7], 64'h8000_0018);
        end

        // SD/LD with 3 wait cycles on the data port
        clear_prog();
        for (int i = 0; i < 64; i++) mem[i] = '0;
        prog[0] = e_i(7'b0010011, 2, 3'b000, 0, 123);
        prog[1] = e_s(0, 2, 16);
        prog[2] = e_i(7'b0000011, 7, 3'b011, 0, 16);
        prog[3] = e_s(0, 7, 24);
        prog[4] = EBRK;
        dmode = 2; dly = 3;
        do_reset();
        run_prog(300, -1);
        chk("sd_mem2", mem[2], 64'd123);
        chk("ld_x7", mem[3], 64'd123);
        if (cq_t.size() >= 2) chk("sd_latency", 64'(cq_t[1] - cq_t[0]), 6);
        dmode = 0;

        // Misaligned load
        clear_prog();
        prog[0] = e_i(7'b0010011, 1, 3'b000, 0, 4);
        prog[1] = e_i(7'b0000011, 2, 3'b011, 1, 0);
        do_reset();
        run_prog(100, -1);
        chk("misal_err", 64'(err), 1);
        chk("misal_ncommit", 64'(cq_pc.size()), 1);

        // Illegal encoding
        clear_prog();
        prog[0] = 32'hFFFF_FFFF;
        do_reset();
        run_prog(100, -1);
        chk("illegal_err", 64'(err), 1);
        chk("illegal_ncommit", 64'(cq_pc.size()), 0);

        // ir == 0 halts cleanly with one commit
        clear_prog();
        do_reset();
        run_prog(100, -1);
        chk("zero_halt", 64'(halt), 1);
        chk("zero_err", 64'(err), 0);
        chk("zero_ncommit", 64'(cq_pc.size()), 1);

        // Reset in the middle of a stalled load, then read back the target register
        clear_prog();
        mem[0] = 64'h1111; mem[2] = 64'hDEAD_BEEF;
        prog[0] = e_i(7'b0000011, 7, 3'b011, 0, 16);
        dmode = 2; dly = 1000;
        do_reset();
        run_prog(100, 2);
        do_reset();
        clear_prog();
        prog[0] = e_s(0, 7, 0);
        prog[1] = EBRK;
        dmode = 0;
        run_prog(100, -1);
        chk("rst_mid_mem_x7", mem[0], 64'h0);

        // Random programs with random handshake pacing
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(20, 50);
            clear_prog();
            for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};
            for (int i = 0; i < n; i++) prog[i] = rand_instr(i, n);
            for (int r = 1; r < 8; r++) prog[n + r - 1] = e_s(0, r, 8 * r);
            prog[n + 7] = EBRK;
            imode = $urandom_range(0, 1);
            dmode = $urandom_range(0, 2);
            dly   = $urandom_range(0, 4);
            do_reset();
            run_prog(2000, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
